// File: rtl/range_stats.sv
// rtl/range_stats.sv - min/max/range/count statistics over a go/finish delimited sample sequence
module range_stats #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8,
  parameter bit SIGNED    = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 data_valid,
  input  logic                 go,
  input  logic                 finish,
  output logic [WIDTH:0]       range,
  output logic [WIDTH-1:0]     min_out,
  output logic [WIDTH-1:0]     max_out,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 done,
  output logic                 busy,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic                 cnt_sat
);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_PROTO = 2'b01;
  localparam logic [1:0] ERR_EMPTY = 2'b10;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     wmin_q, wmax_q, wmin_d, wmax_d;
  logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                 wsat_q, wsat_d;

  // working values with the current sample folded in
  logic [WIDTH-1:0]     s_min, s_max;
  logic [CNT_WIDTH-1:0] s_cnt;
  logic                 s_sat;
  logic                 lt_min, gt_max;
  logic [1:0]           err_d;
  logic                 publish;
  logic [WIDTH:0]       s_range;

  always_comb begin
    if (SIGNED) begin
      lt_min = $signed(data_in) < $signed(wmin_q);
      gt_max = $signed(data_in) > $signed(wmax_q);
    end else begin
      lt_min = data_in < wmin_q;
      gt_max = data_in > wmax_q;
    end
  end

  always_comb begin
    s_min = wmin_q;
    s_max = wmax_q;
    s_cnt = wcnt_q;
    s_sat = wsat_q;
    if (data_valid) begin
      if (wcnt_q == '0) begin
        s_min = data_in;
        s_max = data_in;
      end else begin
        if (lt_min) s_min = data_in;
        if (gt_max) s_max = data_in;
      end
      if (wcnt_q == CNT_MAX) s_sat = 1'b1;
      else                   s_cnt = wcnt_q + CNT_WIDTH'(1);
    end
  end

  // extension keeps the difference exact in WIDTH+1 bits
  always_comb begin
    if (SIGNED) s_range = {s_max[WIDTH-1], s_max} - {s_min[WIDTH-1], s_min};
    else        s_range = {1'b0, s_max} - {1'b0, s_min};
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_code;
    publish = 1'b0;
    wmin_d  = wmin_q;
    wmax_d  = wmax_q;
    wcnt_d  = wcnt_q;
    wsat_d  = wsat_q;
    if (go && finish) begin
      state_d = ERR;
      err_d   = ERR_PROTO;
    end else begin
      case (state_q)
        IDLE, ERR: begin
          if (go) begin
            state_d = RUN;
            err_d   = ERR_NONE;
            wmin_d  = data_valid ? data_in : '0;
            wmax_d  = data_valid ? data_in : '0;
            wcnt_d  = data_valid ? CNT_WIDTH'(1) : '0;
            wsat_d  = 1'b0;
          end else if (finish && state_q == IDLE) begin
            state_d = ERR;
            err_d   = ERR_PROTO;
          end
        end
        RUN: begin
          if (go) begin
            state_d = ERR;
            err_d   = ERR_PROTO;
          end else begin
            wmin_d = s_min;
            wmax_d = s_max;
            wcnt_d = s_cnt;
            wsat_d = s_sat;
            if (finish) begin
              if (s_cnt == '0) begin
                state_d = ERR;
                err_d   = ERR_EMPTY;
              end else begin
                state_d = IDLE;
                publish = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wmin_q   <= '0;
      wmax_q   <= '0;
      wcnt_q   <= '0;
      wsat_q   <= 1'b0;
      range    <= '0;
      min_out  <= '0;
      max_out  <= '0;
      count    <= '0;
      cnt_sat  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      wmin_q   <= wmin_d;
      wmax_q   <= wmax_d;
      wcnt_q   <= wcnt_d;
      wsat_q   <= wsat_d;
      done     <= publish;
      busy     <= (state_d == RUN);
      error    <= (state_d == ERR);
      err_code <= err_d;
      if (publish) begin
        range   <= s_range;
        min_out <= s_min;
        max_out <= s_max;
        count   <= s_cnt;
        cnt_sat <= s_sat;
      end
    end
  end

endmodule

// File: tb/tb_range_stats.sv
// tb/tb_range_stats.sv - self-checking bench for range_stats against a queue-based sequence model
module tb_range_stats;

  logic        clock = 1'b0;
  logic        reset, go, finish, data_valid;
  logic [15:0] data_in;

  logic [16:0] rng  [3];
  logic [15:0] mn   [3];
  logic [15:0] mx   [3];
  logic [7:0]  cnt0, cnt1;
  logic [1:0]  cnt2;
  logic        dn   [3];
  logic        bsy  [3];
  logic        err  [3];
  logic [1:0]  code [3];
  logic        sat  [3];

  always #5 clock = ~clock;

  range_stats #(.WIDTH(16), .CNT_WIDTH(8), .SIGNED(0)) u_uns (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .go(go), .finish(finish), .range(rng[0]), .min_out(mn[0]), .max_out(mx[0]),
    .count(cnt0), .done(dn[0]), .busy(bsy[0]), .error(err[0]),
    .err_code(code[0]), .cnt_sat(sat[0]));

  range_stats #(.WIDTH(16), .CNT_WIDTH(8), .SIGNED(1)) u_sgn (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .go(go), .finish(finish), .range(rng[1]), .min_out(mn[1]), .max_out(mx[1]),
    .count(cnt1), .done(dn[1]), .busy(bsy[1]), .error(err[1]),
    .err_code(code[1]), .cnt_sat(sat[1]));

  range_stats #(.WIDTH(16), .CNT_WIDTH(2), .SIGNED(0)) u_sat (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .go(go), .finish(finish), .range(rng[2]), .min_out(mn[2]), .max_out(mx[2]),
    .count(cnt2), .done(dn[2]), .busy(bsy[2]), .error(err[2]),
    .err_code(code[2]), .cnt_sat(sat[2]));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // model: 0 idle, 1 run, 2 err; samples of the open sequence kept in a queue
  int          mode = 0;
  logic [15:0] samples[$];
  int          e_min [3], e_max [3], e_rng [3], e_cnt [3];
  bit          e_sat [3], e_satok [3];
  bit          e_done, e_busy, e_err;
  int          e_code;

  function automatic int as_int(input logic [15:0] v, input bit sg);
    return sg ? int'($signed(v)) : int'(v);
  endfunction

  task automatic clear_results();
    for (int c = 0; c < 3; c++) begin
      e_min[c] = 0; e_max[c] = 0; e_rng[c] = 0; e_cnt[c] = 0;
      e_sat[c] = 0; e_satok[c] = 1;
    end
  endtask

  task automatic publish_results();
    int n, cap, lo, hi, v;
    n = samples.size();
    for (int c = 0; c < 3; c++) begin
      cap = (c == 2) ? 3 : 255;
      lo = as_int(samples[0], c == 1);
      hi = lo;
      foreach (samples[i]) begin
        v = as_int(samples[i], c == 1);
        if (v < lo) lo = v;
        if (v > hi) hi = v;
      end
      e_min[c]   = lo & 16'hffff;
      e_max[c]   = hi & 16'hffff;
      e_rng[c]   = hi - lo;
      e_cnt[c]   = (n > cap) ? cap : n;
      e_sat[c]   = (n > cap);
      e_satok[c] = (c != 2) || (n != 3);
    end
  endtask

  task automatic model_step(input bit r, g, f, v, input logic [15:0] d);
    e_done = 0;
    if (r) begin
      mode = 0; e_code = 0; samples.delete(); clear_results();
    end else if (g && f) begin
      mode = 2; e_code = 1;
    end else if (mode != 1) begin
      if (g) begin
        mode = 1; e_code = 0; samples.delete();
        if (v) samples.push_back(d);
      end else if (f && mode == 0) begin
        mode = 2; e_code = 1;
      end
    end else if (g) begin
      mode = 2; e_code = 1;
    end else begin
      if (v) samples.push_back(d);
      if (f) begin
        if (samples.size() == 0) begin
          mode = 2; e_code = 2;
        end else begin
          publish_results(); e_done = 1; mode = 0;
        end
      end
    end
    e_busy = (mode == 1);
    e_err  = (mode == 2);
  endtask

  task automatic compare_all();
    logic [31:0] cv [3];
    cv[0] = 32'(cnt0); cv[1] = 32'(cnt1); cv[2] = 32'(cnt2);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("done%0d", c),  32'(dn[c]),   32'(e_done));
      check($sformatf("busy%0d", c),  32'(bsy[c]),  32'(e_busy));
      check($sformatf("error%0d", c), 32'(err[c]),  32'(e_err));
      check($sformatf("code%0d", c),  32'(code[c]), e_code);
      check($sformatf("min%0d", c),   32'(mn[c]),   e_min[c]);
      check($sformatf("max%0d", c),   32'(mx[c]),   e_max[c]);
      check($sformatf("range%0d", c), 32'(rng[c]),  e_rng[c]);
      check($sformatf("count%0d", c), cv[c],        e_cnt[c]);
      if (e_satok[c]) check($sformatf("sat%0d", c), 32'(sat[c]), 32'(e_sat[c]));
    end
  endtask

  task automatic cyc(input bit r, g, f, v, input logic [15:0] d);
    reset = r; go = g; finish = f; data_valid = v; data_in = d;
    @(posedge clock);
    model_step(r, g, f, v, d);
    #1;
    compare_all();
  endtask

  initial begin
    logic [15:0] d;
    reset = 1; go = 0; finish = 0; data_valid = 0; data_in = '0;
    clear_results();
    e_done = 0; e_busy = 0; e_err = 0; e_code = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 16'h1234);
    cyc(0, 0, 0, 1, 16'h0042);

    // basic unsigned sequence
    cyc(0, 1, 0, 1, 5); cyc(0, 0, 0, 1, 9); cyc(0, 0, 0, 1, 2); cyc(0, 0, 1, 1, 7);
    check("basic_min", 32'(mn[0]), 2);
    check("basic_max", 32'(mx[0]), 9);
    check("basic_range", 32'(rng[0]), 7);
    check("basic_count", 32'(cnt0), 4);
    check("basic_done", 32'(dn[0]), 1);
    cyc(0, 0, 0, 0, 0);

    // signed extremes
    cyc(0, 1, 0, 1, 16'h8000); cyc(0, 0, 1, 1, 16'h7fff);
    check("signed_range", 32'(rng[1]), 32'h0ffff);
    check("signed_min", 32'(mn[1]), 32'h8000);
    check("signed_count", 32'(cnt1), 2);

    // empty sequence then recovery
    cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0);
    check("empty_code", 32'(code[0]), 2);
    cyc(0, 0, 1, 1, 16'h0077);
    cyc(0, 1, 0, 1, 3); cyc(0, 0, 1, 0, 0);
    check("recover_range", 32'(rng[0]), 0);
    check("recover_error", 32'(err[0]), 0);

    // protocol errors
    cyc(0, 1, 1, 0, 0);
    check("gofin_code", 32'(code[0]), 1);
    cyc(0, 1, 0, 1, 10); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0);
    check("idle_fin_code", 32'(code[0]), 1);
    cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 1, 4);
    check("run_go_busy", 32'(bsy[0]), 0);

    // saturation on the 2-bit counter
    cyc(0, 1, 0, 1, 11);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 16'(20 + i));
    cyc(0, 0, 1, 0, 0);
    check("sat_count", 32'(cnt2), 3);
    check("sat_flag", 32'(sat[2]), 1);

    // reset mid-sequence
    cyc(0, 1, 0, 1, 1); cyc(0, 0, 0, 1, 100); cyc(1, 0, 1, 1, 50);
    check("rst_range", 32'(rng[0]), 0);
    check("rst_busy", 32'(bsy[0]), 0);
    cyc(0, 0, 1, 0, 0);
    check("rst_fin_code", 32'(code[0]), 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: d = 16'h0000;
        1: d = 16'hffff;
        default: d = 16'($urandom);
      endcase
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 60, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/range_stats.md
RANGE_STATS -- requirements
Module: range_stats

Interface
REQ-001 Parameter WIDTH, default 16: data sample width in bits, minimum 2.
REQ-002 Parameter CNT_WIDTH, default 8: sample counter width in bits, minimum 2.
REQ-003 Parameter SIGNED, default 0: 0 compares samples as unsigned, 1 compares them as two's complement.
REQ-004 clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data_in  input  WIDTH  sample value.
REQ-007 data_valid  input  1  data_in holds a sample this cycle.
REQ-008 go  input  1  start a new sequence.
REQ-009 finish  input  1  end the current sequence.
REQ-010 range  output  WIDTH+1  max_out minus min_out of the last completed sequence.
REQ-011 min_out, max_out  output  WIDTH each  extremes of the last completed sequence, in the SIGNED interpretation.
REQ-012 count  output  CNT_WIDTH  number of valid samples in the last completed sequence, saturating.
REQ-013 done  output  1  one-cycle pulse when new results are presented.
REQ-014 busy  output  1  high while in state RUN.
REQ-015 error  output  1  high while in state ERR.
REQ-016 err_code  output  2  cause of the error: 01 protocol error, 10 empty sequence, 00 no error.
REQ-017 cnt_sat  output  1  count saturated in the last completed sequence.

Function
REQ-018 The block SHALL have three states: IDLE, RUN and ERR; all outputs SHALL be registered.
REQ-019 From IDLE or ERR, go=1 with finish=0 SHALL enter RUN, clear the working min/max/count, and clear error and err_code.
REQ-020 On a start cycle (REQ-019) with data_valid=1, data_in SHALL become the first sample: working min = max = data_in, count = 1.
REQ-021 In RUN, every data_valid=1 cycle SHALL include data_in, including the cycle carrying finish.
- The first included sample loads both working min and max.
- Later samples update working min/max using strict < and > comparisons.
REQ-022 The working count SHALL increment per included sample and saturate at 2^CNT_WIDTH-1; saturation SHALL set the working saturation flag.
REQ-023 In RUN, finish=1 with go=0 and a nonzero count (after including the finish-cycle sample) SHALL return to IDLE.
- On the following cycle: min_out, max_out, count, cnt_sat and range are updated, and done=1 for exactly one cycle.
REQ-024 range SHALL be max_out - min_out computed in WIDTH+1 bits, using sign extension when SIGNED=1 and zero extension when SIGNED=0, so the result never wraps.
REQ-025 In RUN, finish=1 with a zero count SHALL enter ERR with err_code=10; no done pulse; result outputs unchanged.
REQ-026 Any of the following SHALL enter ERR with err_code=01, with result outputs unchanged:
- go and finish both high in the same cycle (any state);
- finish=1 in IDLE;
- go=1 in RUN.
REQ-027 In ERR, data_valid and finish SHALL be ignored; only reset or a start (REQ-019) leaves ERR.
REQ-028 In IDLE, data_valid without go SHALL be ignored.
REQ-029 Result outputs SHALL hold their values until the next successful finish.
REQ-030 done and error SHALL never be high in the same cycle.

Reset
REQ-031 A reset=1 cycle SHALL force IDLE from any state, including mid-sequence, and discard any partial sequence.
REQ-032 Reset SHALL clear range, min_out, max_out, count, done, busy, error, err_code and cnt_sat to 0, effective on the next rising edge.
REQ-033 Reset SHALL take priority over go, finish and data_valid.

Verification
REQ-034 Basic sequence, SIGNED=0: go+valid 5, valid 9, valid 2, finish+valid 7 -> next cycle min_out=2, max_out=9, range=7, count=4, done=1 for one cycle.
REQ-035 Signed sequence, SIGNED=1, WIDTH=16: go+valid 0x8000 (-32768), finish+valid 0x7FFF -> range=0x0FFFF, min_out=0x8000, count=2.
REQ-036 Valid gaps and empty sequence:
- go without valid, one idle cycle, finish without valid -> error=1, err_code=10, results unchanged.
- Then go+valid 3, finish -> error clears; range=0, count=1.
REQ-037 Protocol errors: go+finish together -> err_code=01; finish in IDLE -> err_code=01; go in RUN -> err_code=01 and busy=0 next cycle.
REQ-038 Saturation, CNT_WIDTH=2: go+valid followed by 5 further valid samples, then finish -> count=3, cnt_sat=1.
REQ-039 Reset mid-sequence: reset during RUN after samples 1 and 100 -> all outputs 0 next cycle; a finish afterwards -> err_code=01.
